// File: rtl/bus_arbiter.sv
// bus_arbiter
//   Round-robin arbiter that shares one registered single-master system bus
//   between PORTS requesters (0 = instruction fetch, 1 = data, 2 = DMA).
//   One transaction at a time: the winner's rw/address/wdata are latched onto
//   the bus, held until the slave returns i_bus_ready, then read data is
//   registered back and o_ready pulses to the winner for one cycle.
//   The port that just completed drops to lowest priority on the next grant.
//
//   Optional feature macro: BUS_ARBITER_TIMEOUT_EN
//     When defined, an access that sees no i_bus_ready for TIMEOUT cycles is
//     aborted: o_fault pulses, o_fault_port names the winner, o_rdata reads 0
//     and o_ready still pulses so the requester is released.
//     When undefined, accesses wait indefinitely and o_fault/o_fault_port are 0.
//
// Ports
//   i_clock, i_reset          clock, synchronous active-high reset
//   i_request/i_rw [PORTS]    per-port request and direction (1 = write)
//   i_address/i_wdata         per-port 32-bit fields, port n at [32n+31:32n]
//   o_ready [PORTS]           one-cycle completion pulse to the winner
//   o_rdata                   registered read data, valid with o_ready
//   o_busy [PORTS]            port is requesting while another owns the bus
//   o_bus_request/rw/address/wdata   registered slave-side bus
//   i_bus_ready, i_bus_rdata  slave completion and read data
//   o_fault, o_fault_port     watchdog abort pulse and aborted port index
module bus_arbiter #(
    parameter int PORTS   = 3,
    parameter int TIMEOUT = 1024
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic [PORTS-1:0]    i_request,
    input  logic [PORTS-1:0]    i_rw,
    input  logic [PORTS*32-1:0] i_address,
    input  logic [PORTS*32-1:0] i_wdata,
    output logic [PORTS-1:0]    o_ready,
    output logic [31:0]         o_rdata,
    output logic [PORTS-1:0]    o_busy,
    output logic                o_bus_request,
    output logic                o_bus_rw,
    output logic [31:0]         o_bus_address,
    output logic [31:0]         o_bus_wdata,
    input  logic                i_bus_ready,
    input  logic [31:0]         i_bus_rdata,
    output logic                o_fault,
    output logic [2:0]          o_fault_port
);

    localparam int IDX_W = (PORTS > 1) ? $clog2(PORTS) : 1;

    if (PORTS < 2 || PORTS > 8) begin : g_bad_ports
        $error("bus_arbiter: PORTS must be in 2..8");
    end
    if (TIMEOUT < 1 || TIMEOUT > 65536) begin : g_bad_timeout
        $error("bus_arbiter: TIMEOUT must fit the 16-bit watchdog");
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t             state_r, state_nxt_s;
    logic [IDX_W-1:0]   last_r, last_nxt_s;
    logic [IDX_W-1:0]   winner_r, winner_nxt_s;
    logic               bus_request_r, bus_request_nxt_s;
    logic               bus_rw_r, bus_rw_nxt_s;
    logic [31:0]        bus_address_r, bus_address_nxt_s;
    logic [31:0]        bus_wdata_r, bus_wdata_nxt_s;
    logic [31:0]        rdata_r, rdata_nxt_s;
    logic [PORTS-1:0]   ready_r, ready_nxt_s;
    logic               grant_s, finish_s, expire_s, timeout_hit_s;
    logic [IDX_W:0]     pick_s;
    logic [31:0]        address_arr_s [PORTS];
    logic [31:0]        wdata_arr_s   [PORTS];

    // Round-robin pick: returns {found, index} of the first requester at or after last+1 (wrapping).
    function automatic logic [IDX_W:0] rr_pick(input logic [IDX_W-1:0] last,
                                               input logic [PORTS-1:0] req);
        logic [IDX_W:0]   result;
        logic [IDX_W-1:0] cand;
        result = {(IDX_W+1){1'b0}};
        // Scan farthest-first so the nearest requester after `last` overwrites and wins.
        for (int off = PORTS; off >= 1; off--) begin
            cand = IDX_W'((int'(last) + off) % PORTS);
            if (req[cand]) begin
                result = {1'b1, cand};
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

    for (genvar p = 0; p < PORTS; p++) begin : g_port
        assign address_arr_s[p] = i_address[32*p +: 32];
        assign wdata_arr_s[p]   = i_wdata[32*p +: 32];
        assign o_busy[p] = i_request[p] && (state_r != ST_IDLE) && (winner_r != IDX_W'(p));
    end

    assign pick_s = rr_pick(last_r, i_request);

    // State register.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; slave ready beats watchdog expiry in the same cycle.
    always_comb begin
        state_nxt_s = state_r;
        grant_s     = 1'b0;
        finish_s    = 1'b0;
        expire_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (pick_s[IDX_W]) begin
                    grant_s     = 1'b1;
                    state_nxt_s = ST_ACCESS;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (i_bus_ready) begin
                    finish_s    = 1'b1;
                    state_nxt_s = ST_DONE;
                end else if (timeout_hit_s) begin
                    expire_s    = 1'b1;
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_ACCESS;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output logic: next values for the registered bus, data and handshake outputs.
    always_comb begin
        last_nxt_s        = last_r;
        winner_nxt_s      = winner_r;
        bus_request_nxt_s = bus_request_r;
        bus_rw_nxt_s      = bus_rw_r;
        bus_address_nxt_s = bus_address_r;
        bus_wdata_nxt_s   = bus_wdata_r;
        rdata_nxt_s       = rdata_r;
        ready_nxt_s       = {PORTS{1'b0}};
        if (grant_s) begin
            winner_nxt_s      = pick_s[IDX_W-1:0];
            bus_request_nxt_s = 1'b1;
            bus_rw_nxt_s      = i_rw[pick_s[IDX_W-1:0]];
            bus_address_nxt_s = address_arr_s[pick_s[IDX_W-1:0]];
            bus_wdata_nxt_s   = wdata_arr_s[pick_s[IDX_W-1:0]];
        end else if (finish_s) begin
            bus_request_nxt_s     = 1'b0;
            rdata_nxt_s           = i_bus_rdata;
            ready_nxt_s[winner_r] = 1'b1;
            last_nxt_s            = winner_r;
        end else if (expire_s) begin
            // Aborted port also rotates to lowest priority so a dead slave cannot pin the bus.
            bus_request_nxt_s     = 1'b0;
            rdata_nxt_s           = 32'h0000_0000;
            ready_nxt_s[winner_r] = 1'b1;
            last_nxt_s            = winner_r;
        end else begin
            last_nxt_s = last_r;
        end
    end

    // Registered outputs and arbitration bookkeeping.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            last_r        <= IDX_W'(PORTS - 1);
            winner_r      <= {IDX_W{1'b0}};
            bus_request_r <= 1'b0;
            bus_rw_r      <= 1'b0;
            bus_address_r <= 32'h0000_0000;
            bus_wdata_r   <= 32'h0000_0000;
            rdata_r       <= 32'h0000_0000;
            ready_r       <= {PORTS{1'b0}};
        end else begin
            last_r        <= last_nxt_s;
            winner_r      <= winner_nxt_s;
            bus_request_r <= bus_request_nxt_s;
            bus_rw_r      <= bus_rw_nxt_s;
            bus_address_r <= bus_address_nxt_s;
            bus_wdata_r   <= bus_wdata_nxt_s;
            rdata_r       <= rdata_nxt_s;
            ready_r       <= ready_nxt_s;
        end
    end

`ifdef BUS_ARBITER_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

    logic [15:0] timeout_cnt_r;
    logic        fault_r;
    logic [2:0]  fault_port_r;

    // Counter holds n-1 in the n-th ACCESS cycle, so expiry lands on the TIMEOUT-th cycle.
    assign timeout_hit_s = (timeout_cnt_r == TIMEOUT_LAST);

    // Watchdog counter: cleared on grant, counts every ACCESS cycle.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            timeout_cnt_r <= 16'h0000;
        end else if (grant_s) begin
            timeout_cnt_r <= 16'h0000;
        end else if (state_r == ST_ACCESS) begin
            timeout_cnt_r <= timeout_cnt_r + 16'h0001;
        end else begin
            timeout_cnt_r <= timeout_cnt_r;
        end
    end

    // Fault pulse and sticky index of the last aborted port.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            fault_r      <= 1'b0;
            fault_port_r <= 3'b000;
        end else begin
            fault_r <= expire_s;
            if (expire_s) begin
                fault_port_r <= 3'(winner_r);
            end else begin
                fault_port_r <= fault_port_r;
            end
        end
    end

    assign o_fault      = fault_r;
    assign o_fault_port = fault_port_r;
`else
    assign timeout_hit_s = 1'b0;
    assign o_fault       = 1'b0;
    assign o_fault_port  = 3'b000;
`endif

    assign o_ready       = ready_r;
    assign o_rdata       = rdata_r;
    assign o_bus_request = bus_request_r;
    assign o_bus_rw      = bus_rw_r;
    assign o_bus_address = bus_address_r;
    assign o_bus_wdata   = bus_wdata_r;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed testbench for bus_arbiter (PORTS = 3, TIMEOUT = 8).
// Inputs are driven 1 time unit after the rising edge; outputs are checked
// at that same point, i.e. they show the state registered by that edge.
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic [2:0]  i_request = 3'b000;
    logic [2:0]  i_rw = 3'b000;
    logic [95:0] i_address = 96'd0;
    logic [95:0] i_wdata = 96'd0;
    logic [2:0]  o_ready;
    logic [31:0] o_rdata;
    logic [2:0]  o_busy;
    logic        o_bus_request;
    logic        o_bus_rw;
    logic [31:0] o_bus_address;
    logic [31:0] o_bus_wdata;
    logic        i_bus_ready = 1'b0;
    logic [31:0] i_bus_rdata = 32'd0;
    logic        o_fault;
    logic [2:0]  o_fault_port;

    int checks = 0;
    int errors = 0;
    logic [31:0] port_addr [3];

    bus_arbiter #(.PORTS(3), .TIMEOUT(8)) dut (
        .i_clock(clk), .i_reset(i_reset), .i_request(i_request), .i_rw(i_rw),
        .i_address(i_address), .i_wdata(i_wdata), .o_ready(o_ready), .o_rdata(o_rdata),
        .o_busy(o_busy), .o_bus_request(o_bus_request), .o_bus_rw(o_bus_rw),
        .o_bus_address(o_bus_address), .o_bus_wdata(o_bus_wdata),
        .i_bus_ready(i_bus_ready), .i_bus_rdata(i_bus_rdata),
        .o_fault(o_fault), .o_fault_port(o_fault_port)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        tick();
        tick();
        checks++; if (o_bus_request !== 1'b0 || o_bus_rw !== 1'b0) begin errors++; $display("FAIL reset_bus_ctl: req=%b rw=%b expected 0 0", o_bus_request, o_bus_rw); end
        checks++; if (o_bus_address !== 32'd0 || o_bus_wdata !== 32'd0) begin errors++; $display("FAIL reset_bus_data: addr=%h wdata=%h expected 0 0", o_bus_address, o_bus_wdata); end
        checks++; if (o_ready !== 3'b000 || o_rdata !== 32'd0) begin errors++; $display("FAIL reset_ready: ready=%b rdata=%h expected 000 0", o_ready, o_rdata); end
        checks++; if (o_fault !== 1'b0 || o_fault_port !== 3'd0 || o_busy !== 3'b000) begin errors++; $display("FAIL reset_fault_busy: fault=%b port=%0d busy=%b expected 0 0 000", o_fault, o_fault_port, o_busy); end
        i_reset = 1'b0;
    endtask

    task automatic test_single_read();
        i_request = 3'b010;
        i_rw = 3'b000;
        i_address[63:32] = 32'h1000_0010;
        for (int c = 1; c <= 3; c++) begin
            tick();
            checks++; if (o_bus_request !== 1'b1 || o_bus_address !== 32'h1000_0010 || o_bus_rw !== 1'b0) begin errors++; $display("FAIL single_read_bus c%0d: req=%b addr=%h rw=%b expected 1 10000010 0", c, o_bus_request, o_bus_address, o_bus_rw); end
            checks++; if (o_ready !== 3'b000) begin errors++; $display("FAIL single_read_early_ready c%0d: ready=%b expected 000", c, o_ready); end
        end
        i_bus_ready = 1'b1;
        i_bus_rdata = 32'hCAFE_BABE;
        tick();
        checks++; if (o_ready !== 3'b010 || o_rdata !== 32'hCAFE_BABE) begin errors++; $display("FAIL single_read_done: ready=%b rdata=%h expected 010 cafebabe", o_ready, o_rdata); end
        checks++; if (o_bus_request !== 1'b0) begin errors++; $display("FAIL single_read_req_drop: req=%b expected 0", o_bus_request); end
        i_bus_ready = 1'b0;
        i_request = 3'b000;
        tick();
        checks++; if (o_ready !== 3'b000) begin errors++; $display("FAIL single_read_pulse_len: ready=%b expected 000", o_ready); end
    endtask

    task automatic test_contention();
        logic [1:0] order [6];
        order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd2;
        order[3] = 2'd0; order[4] = 2'd1; order[5] = 2'd2;
        port_addr[0] = 32'h0000_0040;
        port_addr[1] = 32'h1000_0010;
        port_addr[2] = 32'h1000_0100;
        i_address = {port_addr[2], port_addr[1], port_addr[0]};
        i_rw = 3'b000;
        i_reset = 1'b1;
        i_request = 3'b111;
        tick();
        i_reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            checks++; if (o_bus_request !== 1'b1 || o_bus_address !== port_addr[order[k]]) begin errors++; $display("FAIL contention_grant k%0d: req=%b addr=%h expected 1 %h", k, o_bus_request, o_bus_address, port_addr[order[k]]); end
            checks++; if (o_busy !== (3'b111 & ~(3'b001 << order[k]))) begin errors++; $display("FAIL contention_busy k%0d: busy=%b expected %b", k, o_busy, 3'b111 & ~(3'b001 << order[k])); end
            i_bus_ready = 1'b1;
            i_bus_rdata = 32'hD000_0000 + 32'(k);
            tick();
            checks++; if (o_ready !== (3'b001 << order[k]) || o_rdata !== 32'hD000_0000 + 32'(k)) begin errors++; $display("FAIL contention_ready k%0d: ready=%b rdata=%h expected %b %h", k, o_ready, o_rdata, 3'b001 << order[k], 32'hD000_0000 + 32'(k)); end
            i_bus_ready = 1'b0;
            tick();
            checks++; if (o_busy !== 3'b000 || o_bus_request !== 1'b0) begin errors++; $display("FAIL contention_idle k%0d: busy=%b req=%b expected 000 0", k, o_busy, o_bus_request); end
        end
        i_request = 3'b000;
        tick();
    endtask

    task automatic test_write();
        i_request = 3'b100;
        i_rw = 3'b100;
        i_address[95:64] = 32'h1000_0100;
        i_wdata[95:64] = 32'h1234_5678;
        for (int c = 1; c <= 3; c++) begin
            tick();
            checks++; if (o_bus_request !== 1'b1 || o_bus_rw !== 1'b1 || o_bus_address !== 32'h1000_0100 || o_bus_wdata !== 32'h1234_5678) begin errors++; $display("FAIL write_bus c%0d: req=%b rw=%b addr=%h wdata=%h expected 1 1 10000100 12345678", c, o_bus_request, o_bus_rw, o_bus_address, o_bus_wdata); end
        end
        i_bus_ready = 1'b1;
        i_bus_rdata = 32'h0;
        tick();
        checks++; if (o_ready !== 3'b100 || o_bus_request !== 1'b0) begin errors++; $display("FAIL write_done: ready=%b req=%b expected 100 0", o_ready, o_bus_request); end
        i_bus_ready = 1'b0;
        i_request = 3'b000;
        i_rw = 3'b000;
        tick();
    endtask

    task automatic test_reset_mid_access();
        // Port 0 completes so that, without reset, port 1 would be next in line.
        i_request = 3'b001;
        tick();
        i_bus_ready = 1'b1;
        i_bus_rdata = 32'h1111_2222;
        tick();
        checks++; if (o_ready !== 3'b001 || o_rdata !== 32'h1111_2222) begin errors++; $display("FAIL rst_mid_pre: ready=%b rdata=%h expected 001 11112222", o_ready, o_rdata); end
        i_bus_ready = 1'b0;
        i_request = 3'b000;
        tick();
        i_request = 3'b010;
        tick();
        checks++; if (o_bus_request !== 1'b1 || o_bus_address !== 32'h1000_0010) begin errors++; $display("FAIL rst_mid_access: req=%b addr=%h expected 1 10000010", o_bus_request, o_bus_address); end
        i_reset = 1'b1;
        tick();
        checks++; if (o_bus_request !== 1'b0 || o_bus_address !== 32'd0 || o_bus_wdata !== 32'd0 || o_bus_rw !== 1'b0) begin errors++; $display("FAIL rst_mid_bus: req=%b addr=%h wdata=%h rw=%b expected all 0", o_bus_request, o_bus_address, o_bus_wdata, o_bus_rw); end
        checks++; if (o_ready !== 3'b000 || o_rdata !== 32'd0 || o_busy !== 3'b000) begin errors++; $display("FAIL rst_mid_out: ready=%b rdata=%h busy=%b expected 000 0 000", o_ready, o_rdata, o_busy); end
        i_request = 3'b111;
        i_reset = 1'b0;
        tick();
        checks++; if (o_bus_address !== 32'h0000_0040 || o_busy !== 3'b110) begin errors++; $display("FAIL rst_mid_first_grant: addr=%h busy=%b expected 00000040 110", o_bus_address, o_busy); end
        i_bus_ready = 1'b1;
        i_bus_rdata = 32'h3333_4444;
        tick();
        checks++; if (o_ready !== 3'b001) begin errors++; $display("FAIL rst_mid_first_ready: ready=%b expected 001", o_ready); end
        i_bus_ready = 1'b0;
        i_request = 3'b000;
        tick();
    endtask

    task automatic test_ready_outside_access();
        i_bus_ready = 1'b1;
        i_bus_rdata = 32'hDEAD_BEEF;
        tick();
        tick();
        checks++; if (o_ready !== 3'b000 || o_rdata !== 32'h3333_4444 || o_bus_request !== 1'b0) begin errors++; $display("FAIL stray_ready: ready=%b rdata=%h req=%b expected 000 33334444 0", o_ready, o_rdata, o_bus_request); end
        i_bus_ready = 1'b0;
    endtask

`ifdef BUS_ARBITER_TIMEOUT_EN
    task automatic test_timeout(input logic ready_at_expiry);
        i_request = 3'b010;
        i_address[63:32] = 32'h3000_0000;
        tick();
        for (int c = 2; c <= 8; c++) begin
            tick();
            checks++; if (o_bus_request !== 1'b1 || o_fault !== 1'b0 || o_ready !== 3'b000) begin errors++; $display("FAIL timeout_wait c%0d: req=%b fault=%b ready=%b expected 1 0 000", c, o_bus_request, o_fault, o_ready); end
        end
        i_bus_ready = ready_at_expiry;
        i_bus_rdata = 32'h5A5A_5A5A;
        tick();
        checks++; if (o_ready !== 3'b010 || o_bus_request !== 1'b0) begin errors++; $display("FAIL timeout_release: ready=%b req=%b expected 010 0", o_ready, o_bus_request); end
        if (ready_at_expiry) begin
            checks++; if (o_fault !== 1'b0 || o_rdata !== 32'h5A5A_5A5A) begin errors++; $display("FAIL expiry_ready_wins: fault=%b rdata=%h expected 0 5a5a5a5a", o_fault, o_rdata); end
        end else begin
            checks++; if (o_fault !== 1'b1 || o_fault_port !== 3'd1 || o_rdata !== 32'd0) begin errors++; $display("FAIL timeout_fault: fault=%b port=%0d rdata=%h expected 1 1 0", o_fault, o_fault_port, o_rdata); end
        end
        i_bus_ready = 1'b0;
        i_request = 3'b000;
        tick();
        checks++; if (o_fault !== 1'b0 || o_ready !== 3'b000) begin errors++; $display("FAIL timeout_pulse_len: fault=%b ready=%b expected 0 000", o_fault, o_ready); end
    endtask
`else
    task automatic test_no_timeout();
        i_request = 3'b010;
        i_address[63:32] = 32'h3000_0000;
        for (int c = 1; c <= 20; c++) begin
            tick();
            checks++; if (o_bus_request !== 1'b1 || o_fault !== 1'b0 || o_ready !== 3'b000) begin errors++; $display("FAIL no_timeout_wait c%0d: req=%b fault=%b ready=%b expected 1 0 000", c, o_bus_request, o_fault, o_ready); end
        end
        i_bus_ready = 1'b1;
        i_bus_rdata = 32'h0BAD_F00D;
        tick();
        checks++; if (o_ready !== 3'b010 || o_rdata !== 32'h0BAD_F00D || o_fault !== 1'b0) begin errors++; $display("FAIL no_timeout_done: ready=%b rdata=%h fault=%b expected 010 0badf00d 0", o_ready, o_rdata, o_fault); end
        i_bus_ready = 1'b0;
        i_request = 3'b000;
        tick();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_read();
        test_contention();
        test_write();
        test_reset_mid_access();
        test_ready_outside_access();
`ifdef BUS_ARBITER_TIMEOUT_EN
        test_timeout(1'b0);
        test_timeout(1'b1);
`else
        test_no_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Round-robin arbiter sharing one registered single-master system bus (ROM/RAM/peripheral decode side) between `PORTS` requesters: CPU instruction fetch, CPU data access and DMA. It sits between the requesters and the address-decoded slave bus. It grants one transaction at a time, holds the bus until the slave returns ready, registers read data back to the winner, and rotates priority so no port starves.

## Interface
Parameters:
- `PORTS`, 3: number of requesters (2..8); port 0 = instruction, 1 = data, 2 = DMA.
- `TIMEOUT`, 1024: access watchdog limit in cycles; used only with `BUS_ARBITER_TIMEOUT_EN`.

Ports:
- `i_clock`  in  1  single clock; everything synchronous to rising edge.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_request`  in  PORTS  per-port request; held with address/rw/wdata until that port's `o_ready`.
- `i_rw`  in  PORTS  per-port direction, 1 = write.
- `i_address`  in  PORTS*32  per-port address, port n at bits [32n+31:32n].
- `i_wdata`  in  PORTS*32  per-port write data, same packing.
- `o_ready`  out  PORTS  one-cycle completion pulse to the granted port.
- `o_rdata`  out  32  registered read data, shared; valid while `o_ready` is high.
- `o_busy`  out  PORTS  port requesting but another port owns the bus.
- `o_bus_request`  out  1  bus request, held through the access.
- `o_bus_rw`  out  1  bus direction.
- `o_bus_address`  out  32  bus address.
- `o_bus_wdata`  out  32  bus write data.
- `i_bus_ready`  in  1  slave completion, one cycle.
- `i_bus_rdata`  in  32  slave read data, valid with `i_bus_ready`.
- `o_fault`  out  1  one-cycle watchdog abort pulse.
- `o_fault_port`  out  3  index of the port whose access aborted.

## Operation
- States: IDLE, ACCESS, DONE.
- **IDLE**
  - If any `i_request` bit is set, select the winner by round-robin starting at `last+1` mod `PORTS`.
  - Latch the winner's index, rw, address and wdata into the bus registers.
  - Set `o_bus_request`; go to ACCESS.
  - If no bit is set, stay in IDLE.
- **ACCESS**
  - Bus outputs stay constant and `o_bus_request` stays high until `i_bus_ready`.
  - On `i_bus_ready`: latch `i_bus_rdata` into `o_rdata` (writes latch it too; the value is don't-care), clear `o_bus_request`, set `last` = winner, go to DONE.
- **DONE**
  - `o_ready[winner]` is high for exactly one cycle; go to IDLE.
  - The requester must drop `i_request`, or present a new transaction, by the next edge.
- `o_busy[n]` = `i_request[n]` && state != IDLE && winner != n. It is combinational from registered state.
- Requests arriving during ACCESS or DONE wait. They are not lost, because requests are level-held.
- Simultaneous requests in IDLE: the lowest index at or after `last+1` (wrapping) wins.
- A port that just completed has lowest priority on the next arbitration.
- With only one requester active, it wins every time.
- `i_bus_ready` outside ACCESS is ignored.
- Reset values:
  - state = IDLE, `last` = `PORTS`-1 (so port 0 has first priority).
  - `o_bus_request`, `o_bus_rw`, `o_ready`, `o_fault` = 0.
  - `o_bus_address`, `o_bus_wdata`, `o_rdata` = 0; `o_fault_port` = 0.
- Reset mid-access: `o_bus_request` drops at the reset edge and no `o_ready` is issued. Slaves must tolerate the abandoned access.

## Timing
- Request sampled in IDLE at cycle 0 → `o_bus_request` high in cycle 1.
- Slave ready in cycle k (k ≥ 1) → `o_ready` and `o_rdata` in cycle k+1 → IDLE in cycle k+2.
- Minimum turnaround: 3 cycles per transaction. Zero-wait slave: request at 0, ready at 2.
- Back-to-back different ports: the next grant is sampled in IDLE, so the next `o_bus_request` rises 3 cycles after the previous one.
- No combinational path from `i_request` or `i_bus_*` to any bus output or `o_ready`.

## Configuration
- `BUS_ARBITER_TIMEOUT_EN` defined:
  - A 16-bit counter clears on entry to ACCESS and increments every ACCESS cycle.
  - When it reaches `TIMEOUT` without `i_bus_ready`: clear `o_bus_request`, set `o_rdata` = 0, pulse `o_fault`, latch `o_fault_port` = winner, go to DONE (`o_ready` still pulses to release the requester).
  - `i_bus_ready` in the same cycle as expiry takes precedence: normal completion, no fault.
- Not defined: no counter, ACCESS waits indefinitely, `o_fault` and `o_fault_port` tied to 0.

## Test plan
- **Single read:** port 1 reads 0x10000010; slave answers 0xCAFEBABE after 2 wait cycles → one `o_ready[1]` pulse, `o_rdata`=0xCAFEBABE, `o_bus_request` high exactly 3 cycles.
- **Three-way contention:** all ports request continuously from reset → grant order 0,1,2,0,1,2; `o_busy` set on the two waiting ports during each access.
- **Write passthrough:** port 2 writes 0x12345678 to 0x10000100 → bus shows rw=1 with that address and data, stable until `i_bus_ready`; `o_ready[2]` follows one cycle later.
- **Reset mid-access:** assert `i_reset` during ACCESS → next cycle all outputs are 0, state IDLE; port 0 wins the first grant after release.
- **Timeout** (`BUS_ARBITER_TIMEOUT_EN`, `TIMEOUT`=8): access to unmapped 0x30000000 with no ready → `o_fault` pulses after 8 ACCESS cycles, `o_fault_port`=requester, `o_ready` pulses, `o_rdata`=0.
- **Ready at expiry:** `i_bus_ready` arrives in the expiry cycle → normal completion, `o_fault`=0.
